// File: rtl/pulse_pkg.sv
// Shared types and widths for the pulse sequencer and its
// control block.
package pulse_pkg;

    localparam int PER_W = 32;
    localparam int WID_W = 16;
    localparam int BLK_W = 8;
    localparam int SEG_W = WID_W + 1;

    localparam int DEF_N_ECHO  = 8;
    localparam int DEF_PER_MIN = 4;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        GAP1,
        P2,
        GAPN,
        HOLD,
        DONE
    } state_t;

    function automatic logic [PER_W-1:0] clamp_per(
        input logic [PER_W-1:0] p,
        input logic [PER_W-1:0] pmin
    );
        return (p < pmin) ? pmin : p;
    endfunction

endpackage

// File: rtl/pulse_sequencer_seg_timer.sv
// Loadable segment down-counter; reloaded at each segment
// boundary, flags the last cycle of a segment.
module seg_timer
    import pulse_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [SEG_W-1:0] ld_val,
    output logic             last,
    output logic             zero
);

    logic [SEG_W-1:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (ld) begin
            rem <= ld_val;
        end else if (rem != '0) begin
            rem <= rem - 1'b1;
        end
    end

    assign last = (rem == SEG_W'(1));
    assign zero = (rem == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Period sync, P1/P2 (or CPMG train) drive and receiver blanking,
// with shadowed parameters that switch only at period boundaries.
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int N_ECHO  = DEF_N_ECHO,
    parameter int PER_MIN = DEF_PER_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PER_W-1:0] per,
    input  logic [WID_W-1:0] p1wid,
    input  logic [WID_W-1:0] del,
    input  logic [WID_W-1:0] p2wid,
    input  logic             cp,
    input  logic [BLK_W-1:0] p_bl,
    input  logic             bl,
    input  logic             upd,
    output logic             sync,
    output logic             pulse,
    output logic             inhib,
    output logic             busy,
    output logic             ovr
);

    localparam int EW = $clog2(N_ECHO + 1);

    state_t state, nxt_state;
    state_t h_st, p2_st, g1_st, p1_st, gn_st, ap_st;

    logic [PER_W-1:0] cnt, nxt_cnt, per_s;
    logic [WID_W-1:0] p1_s, del_s, p2_s;
    logic [BLK_W-1:0] pbl_s;
    logic             cp_s, bl_s, pending;
    logic [EW-1:0]    echo, nxt_echo;

    logic [WID_W-1:0] p1_e, del_e, p2_e;
    logic [BLK_W-1:0] pbl_e;
    logic             cp_e, bl_e;
    logic [SEG_W-1:0] dbl_e, ld_val;

    logic start, wrap, ld_sh, ld, seg_end, t_last, t_zero;
    logic sync_n, pulse_n, inhib_n, busy_n, ovr_n;

    assign start = en && (state == IDLE);
    assign wrap  = en && (state != IDLE) && (cnt == per_s - 32'd1);
    assign ld_sh = (start || wrap) && pending;

    // The restarting period must already see the freshly loaded set.
    assign p1_e  = ld_sh ? p1wid : p1_s;
    assign del_e = ld_sh ? del   : del_s;
    assign p2_e  = ld_sh ? p2wid : p2_s;
    assign pbl_e = ld_sh ? p_bl  : pbl_s;
    assign cp_e  = ld_sh ? cp    : cp_s;
    assign bl_e  = ld_sh ? bl    : bl_s;
    assign dbl_e = {del_e, 1'b0};

    assign h_st  = (pbl_e != '0) ? HOLD : DONE;
    assign p2_st = (p2_e != '0) ? P2 : h_st;
    assign g1_st = (del_e != '0) ? GAP1 : p2_st;
    assign p1_st = (p1_e != '0) ? P1 : g1_st;
    assign gn_st = (dbl_e != '0) ? GAPN : P2;
    assign ap_st = (cp_e && echo != '0) ? gn_st : h_st;

    seg_timer u_tmr (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .ld_val (ld_val),
        .last   (t_last),
        .zero   (t_zero)
    );

    assign seg_end = t_last || t_zero;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_echo  = echo;
        ld        = 1'b0;
        if (!en) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else if (start || wrap) begin
            nxt_state = p1_st;
            nxt_cnt   = '0;
            nxt_echo  = EW'(N_ECHO - 1);
            ld        = 1'b1;
        end else begin
            nxt_cnt = cnt + 32'd1;
            if (seg_end) begin
                ld = 1'b1;
                unique case (state)
                    P1:   nxt_state = g1_st;
                    GAP1: nxt_state = p2_st;
                    P2: begin
                        nxt_state = ap_st;
                        if (cp_e && echo != '0) nxt_echo = echo - 1'b1;
                    end
                    GAPN: nxt_state = P2;
                    HOLD: nxt_state = DONE;
                    default: ld = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        ld_val = '0;
        unique case (nxt_state)
            P1:   ld_val = {1'b0, p1_e};
            GAP1: ld_val = {1'b0, del_e};
            P2:   ld_val = {1'b0, p2_e};
            GAPN: ld_val = dbl_e;
            HOLD: ld_val = SEG_W'(pbl_e);
            default: ld_val = '0;
        endcase
    end

    assign sync_n  = start || wrap;
    assign pulse_n = (nxt_state == P1) ? bl_e : (nxt_state == P2);
    assign busy_n  = !(nxt_state inside {IDLE, DONE});
    assign inhib_n = busy_n || sync_n;
    assign ovr_n   = ovr || (wrap && state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            echo    <= '0;
            pending <= 1'b1;
            per_s   <= PER_W'(PER_MIN);
            p1_s    <= '0;
            del_s   <= '0;
            p2_s    <= '0;
            pbl_s   <= '0;
            cp_s    <= 1'b0;
            bl_s    <= 1'b0;
            sync    <= 1'b0;
            pulse   <= 1'b0;
            inhib   <= 1'b0;
            busy    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            echo    <= nxt_echo;
            pending <= upd || (pending && !ld_sh);
            if (ld_sh) begin
                per_s <= clamp_per(per, PER_W'(PER_MIN));
                p1_s  <= p1wid;
                del_s <= del;
                p2_s  <= p2wid;
                pbl_s <= p_bl;
                cp_s  <= cp;
                bl_s  <= bl;
            end
            sync  <= sync_n;
            pulse <= pulse_n;
            inhib <= inhib_n;
            busy  <= busy_n;
            ovr   <= ovr_n;
        end
    end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Turns the registered pulse parameters from the UART control block into real-time outputs: a period sync, a two-pulse (or CPMG echo train) drive signal, and a receiver-protect blanking gate.
- Holds shadow copies of all parameters. A new parameter set takes effect only at a period boundary, so a UART update never corrupts a sequence that is in flight.
- Sits between the control block and the RF switch / attenuator pins, in the 201 MHz clock domain.

Parameters:
- N_ECHO, 8, number of refocusing pulses (P2) per period when CPMG is enabled; minimum 1.
- PER_MIN, 4, smallest period in cycles; smaller per values are clamped up to this.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 holds the sequencer idle.
- per  in  32  period in cycles.
- p1wid  in  16  P1 width in cycles.
- del  in  16  P1-to-P2 gap in cycles.
- p2wid  in  16  P2 width in cycles.
- cp  in  1  1 selects a CPMG train, 0 a single P2.
- p_bl  in  8  blanking hold-off after the last pulse, in cycles.
- bl  in  1  1 enables the P1 output, 0 suppresses it (timing is preserved).
- upd  in  1  one-cycle strobe meaning new parameters are valid (rx_done).
- sync  out  1  high for the first cycle of each period.
- pulse  out  1  RF switch drive.
- inhib  out  1  receiver blanking gate.
- busy  out  1  high while a pulse sequence is active.
- ovr  out  1  sticky flag: the sequence did not fit in the period.

Behaviour:
- All outputs are registered.
- Reset: sync, pulse, inhib, busy and ovr are 0; the period counter is 0; the state is IDLE; an internal pending-load flag is set to 1.
- Reset asserted mid-sequence forces all of the above state within one cycle.
- Shadow registers:
  - upd sets pending.
  - When pending=1 and the period counter wraps (or in IDLE when en rises), all inputs are copied to the shadows and pending is cleared.
  - upd arriving in the same cycle as a load sets pending again, so it applies at the next boundary.
  - per is clamped to max(per, PER_MIN).
- Period counter:
  - Counts 0 .. per_s-1 while en=1, then wraps to 0.
  - en=0 returns to IDLE at the end of the current cycle; outputs go 0 and the counter goes 0.
- Timing, with t = counter value (sync is high at t=0):
  - P1: pulse = bl_s for t in [0, p1wid_s-1].
  - GAP1: pulse = 0 for the next del_s cycles.
  - P2: pulse = 1 for the next p2wid_s cycles.
  - cp_s=1: after P2, repeat {pulse=0 for 2*del_s cycles (17-bit arithmetic), pulse=1 for p2wid_s cycles} another N_ECHO-1 times.
  - HOLD: pulse=0 and inhib stays 1 for p_bl_s cycles, then DONE.
  - inhib = 1 from t=0 through the end of HOLD; busy = 1 in every state except IDLE and DONE.
- State machine:
  - IDLE -> P1 on the load/start.
  - P1 -> GAP1 -> P2 -> (cp_s and echoes remaining ? GAPN -> P2 : HOLD) -> DONE.
  - DONE -> P1 on wrap.
  - A 16-bit segment counter and an echo counter sized clog2(N_ECHO+1) drive the transitions.
- Zero-length segments (p1wid_s, del_s, p2wid_s or p_bl_s = 0) are skipped with no idle cycle inserted.
  - All-zero widths give pulse constantly 0 and inhib high only for t=0.
- Overrun: if the wrap occurs in any state other than DONE:
  - The sequence is truncated.
  - pulse and inhib drop at t=0 of the new period only if the restarting P1 does not itself drive them.
  - ovr sets and stays set until rst.
- sync rises one cycle after en rises from IDLE; that cycle is t=0.

Decomposition:
- Shared package pulse_pkg:
  - State enum: IDLE, P1, GAP1, P2, GAPN, HOLD, DONE.
  - Width constants: PER_W=32, WID_W=16, BLK_W=8.
  - Default parameter values shared with the control block.
- One sub-module: seg_timer, a loadable 16/17-bit down-counter with a zero flag and a skip-on-zero output. It is instantiated once and reloaded at each segment boundary.

Test Plan:
- Basic pair: per=100, p1wid=4, del=10, p2wid=8, cp=0, p_bl=5, bl=1 -> sync at t=0; pulse high t=0..3 and t=14..21; inhib high t=0..26; next sync 100 cycles later.
- CPMG: same settings with cp=1, N_ECHO=3 -> P2 high at t=14..21, 42..49 and 70..77; inhib falls after t=82.
- Shadowed update: pulse upd with p1wid=20 at t=2 of period k -> period k still shows a 4-cycle P1; period k+1 shows a 20-cycle P1; no glitch in between.
- Overrun and clamp: per=20 with the basic pair -> truncation at t=19, ovr=1 and stays set; per=1 -> behaves as period 4.
- bl=0 and zero widths: bl=0 -> no P1 pulse, but P2 still at t=14; p1wid=0, del=0 -> P2 starts at t=0 coincident with sync.
- Reset mid-P2: rst=1 at t=16 -> next cycle all outputs 0; after release with en=1, shadows load and sync asserts one cycle later.
